coeff_load_master: RTL and testbench

Coefficient download sequencer for the FIR filter tops. It accepts a stream of 16-bit tap coefficients over a valid/ready handshake and buffers them in a small FIFO. It then drives the filter's coefficient-RAM write port: the update flag, active-low chip select and write strobe, address and data. It sits between the host/config logic and the filter, and issues one complete, address-ordered load of all taps per start request.

---
 rtl/coeff_load_master.sv | 191 +++++++++++++++++++
 tb/tb_coeff_load_master.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coeff_load_master.sv
`default_nettype none
// ============================================================================
//  Module      : coeff_load_master
//  Description : Coefficient download sequencer for the FIR filter tops.
//                Buffers a valid/ready stream of tap coefficients in a small
//                FIFO and replays it as one address-ordered write burst into
//                the filter's coefficient RAM per start request.
//                Optional feature macro: COEFF_CHECKSUM_EN (running 16-bit
//                sum of the words strobed into RAM on oChecksum).
//  Revision    : 1.0 - initial release
// ============================================================================
module coeff_load_master #(
  parameter int DATA_W     = 16,
  parameter int NUM_TAPS   = 33,
  parameter int ADDR_W     = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              iClk_12M,
  input  logic              iRsn,
  input  logic              iStart,
  input  logic              iAbort,
  input  logic              iCoeffValid,
  input  logic [DATA_W-1:0] iCoeffData,
  output logic              oCoeffReady,
  output logic              oCoeffiUpdateFlag,
  output logic              oCsnRam,
  output logic              oWrnRam,
  output logic [ADDR_W-1:0] oAddrRam,
  output logic [DATA_W-1:0] oWrDtRam,
  output logic              oBusy,
  output logic              oDone,
  output logic [15:0]       oChecksum
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FILL_W = PTR_W + 1;
  localparam int CNT_W  = $clog2(NUM_TAPS + 1);

  localparam logic [CNT_W-1:0]  TAPS      = CNT_W'(NUM_TAPS);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(FIFO_DEPTH);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]        state;
  logic [2:0]        next_state;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [FILL_W-1:0] fifo_fill;
  logic [DATA_W-1:0] pop_data;

  logic [CNT_W-1:0]  accept_cnt;
  logic [CNT_W-1:0]  write_cnt;

  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              start_ok;
  logic              abort_ok;
  logic              flush;

  assign fifo_full  = (fifo_fill == FILL_FULL);
  assign fifo_empty = (fifo_fill == '0);
  assign pop_data   = fifo_mem[rd_ptr];

  // Ready is the only unregistered output: it must fall in the same cycle the
  // FIFO fills or the last tap is taken so no extra word slips in.
  assign oCoeffReady = ((state == ST_SETUP) || (state == ST_WRITE)) &&
                       !fifo_full && (accept_cnt < TAPS);

  assign push     = iCoeffValid && oCoeffReady;
  // Abort has priority over start in IDLE and over a pending write elsewhere.
  assign start_ok = (state == ST_IDLE) && iStart && !iAbort;
  assign abort_ok = iAbort && (state != ST_IDLE);
  assign pop      = (state == ST_WRITE) && !fifo_empty && !iAbort;
  assign flush    = start_ok || abort_ok;

  // Next-state decode; abort from any active state returns to IDLE.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (start_ok) next_state = ST_SETUP;
      ST_SETUP: next_state = ST_WRITE;
      ST_WRITE: if (write_cnt == TAPS) next_state = ST_HOLD;
      ST_HOLD:  next_state = ST_DONE;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
    if (abort_ok) next_state = ST_IDLE;
  end

  // State register.
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FIFO storage; contents need no reset because the fill level gates reads.
  always_ff @(posedge iClk_12M) begin
    if (push && !flush) begin
      fifo_mem[wr_ptr] <= iCoeffData;
    end
  end

  // FIFO pointers and fill level, flushed on every start and abort.
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_fill <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_fill <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_fill <= fifo_fill + 1'b1;
        2'b01:   fifo_fill <= fifo_fill - 1'b1;
        default: fifo_fill <= fifo_fill;
      endcase
    end
  end

  // Words accepted from the source and words written to RAM in this load;
  // the write count doubles as the next RAM address.
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      accept_cnt <= '0;
      write_cnt  <= '0;
    end else if (flush) begin
      accept_cnt <= '0;
      write_cnt  <= '0;
    end else begin
      if (push) accept_cnt <= accept_cnt + 1'b1;
      if (pop)  write_cnt  <= write_cnt + 1'b1;
    end
  end

  // Registered status and RAM port; a pop this cycle becomes a strobe next.
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      oCoeffiUpdateFlag <= 1'b0;
      oBusy             <= 1'b0;
      oDone             <= 1'b0;
      oCsnRam           <= 1'b1;
      oWrnRam           <= 1'b1;
      oAddrRam          <= '0;
      oWrDtRam          <= '0;
    end else begin
      oCoeffiUpdateFlag <= (next_state == ST_SETUP) ||
                           (next_state == ST_WRITE) ||
                           (next_state == ST_HOLD);
      oBusy             <= (next_state != ST_IDLE);
      oDone             <= (next_state == ST_DONE);
      oCsnRam           <= !pop;
      oWrnRam           <= !pop;
      if (pop) begin
        oAddrRam <= ADDR_W'(write_cnt);
        oWrDtRam <= pop_data;
      end
    end
  end

`ifdef COEFF_CHECKSUM_EN
  // Running mod-2^16 sum of every word strobed into RAM in the current load.
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      oChecksum <= 16'h0000;
    end else if (start_ok) begin
      oChecksum <= 16'h0000;
    end else if (pop) begin
      oChecksum <= oChecksum + 16'(pop_data);
    end
  end
`else
  assign oChecksum = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_coeff_load_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_coeff_load_master
//  Description : Self-checking bench for coeff_load_master. A queue-based
//                reference model predicts every output each cycle; a few
//                hand-computed literals pin the model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_coeff_load_master;

  localparam int NT = 33;
  localparam int FD = 4;

  localparam int P_IDLE  = 0;
  localparam int P_SETUP = 1;
  localparam int P_WRITE = 2;
  localparam int P_HOLD  = 3;
  localparam int P_DONE  = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        iStart;
  logic        iAbort;
  logic        iCoeffValid;
  logic [15:0] iCoeffData;
  logic        oCoeffReady;
  logic        oCoeffiUpdateFlag;
  logic        oCsnRam;
  logic        oWrnRam;
  logic [5:0]  oAddrRam;
  logic [15:0] oWrDtRam;
  logic        oBusy;
  logic        oDone;
  logic [15:0] oChecksum;

  coeff_load_master dut (
    .iClk_12M          (clk),
    .iRsn              (rst_n),
    .iStart            (iStart),
    .iAbort            (iAbort),
    .iCoeffValid       (iCoeffValid),
    .iCoeffData        (iCoeffData),
    .oCoeffReady       (oCoeffReady),
    .oCoeffiUpdateFlag (oCoeffiUpdateFlag),
    .oCsnRam           (oCsnRam),
    .oWrnRam           (oWrnRam),
    .oAddrRam          (oAddrRam),
    .oWrDtRam          (oWrDtRam),
    .oBusy             (oBusy),
    .oDone             (oDone),
    .oChecksum         (oChecksum)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- stimulus source ----------------
  logic [15:0] src [64];
  int          nwords = 0;
  int          si     = 0;
  int          vmode  = 0;
  int          cyc3   = 0;
  bit          hs_q   = 0;

  // ---------------- observation ----------------
  logic [15:0] img [64];
  int          nstrobe = 0;
  int          ndone   = 0;

  // ---------------- reference model ----------------
  int          m_phase = P_IDLE;
  logic [15:0] m_q[$];
  int          m_acc = 0;
  int          m_wr  = 0;
  bit          m_push, m_pop, m_allw;
  logic        e_flag = 0, e_csn = 1, e_busy = 0, e_done = 0;
  logic [5:0]  e_addr = 0;
  logic [15:0] e_data = 0, e_sum = 0;

  function automatic bit m_ready();
    return ((m_phase == P_SETUP) || (m_phase == P_WRITE)) &&
           (m_q.size() < FD) && (m_acc < NT);
  endfunction

  initial begin : model
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_phase = P_IDLE;
        m_q.delete();
        m_acc = 0; m_wr = 0;
        e_flag = 0; e_csn = 1; e_addr = 0; e_data = 0;
        e_busy = 0; e_done = 0; e_sum = 0;
      end else begin
        m_push = iCoeffValid && m_ready();
        m_pop  = (m_phase == P_WRITE) && (m_q.size() > 0) && !iAbort;
        m_allw = (m_wr == NT);
        e_csn  = 1;
        if (m_pop) begin
          e_csn  = 0;
          e_addr = 6'(m_wr);
          e_data = m_q.pop_front();
          m_wr++;
`ifdef COEFF_CHECKSUM_EN
          e_sum = e_sum + e_data;
`endif
        end
        if (m_push) begin
          m_q.push_back(iCoeffData);
          m_acc++;
        end
        if (m_phase == P_IDLE) begin
          if (iStart && !iAbort) begin
            m_phase = P_SETUP;
            m_q.delete();
            m_acc = 0; m_wr = 0; e_sum = 0;
          end
        end else if (iAbort) begin
          m_phase = P_IDLE;
          m_q.delete();
        end else begin
          case (m_phase)
            P_SETUP: m_phase = P_WRITE;
            P_WRITE: if (m_allw) m_phase = P_HOLD;
            P_HOLD:  m_phase = P_DONE;
            default: m_phase = P_IDLE;
          endcase
        end
        e_flag = (m_phase == P_SETUP) || (m_phase == P_WRITE) || (m_phase == P_HOLD);
        e_busy = (m_phase != P_IDLE);
        e_done = (m_phase == P_DONE);
      end
    end
  end

  // Per-cycle comparison, strobe recording and handshake sampling.
  initial begin : compare
    forever begin
      @(negedge clk);
      check("ready",    oCoeffReady,       m_ready());
      check("flag",     oCoeffiUpdateFlag, e_flag);
      check("csn",      oCsnRam,           e_csn);
      check("wrn",      oWrnRam,           e_csn);
      check("busy",     oBusy,             e_busy);
      check("done",     oDone,             e_done);
      check("addr",     oAddrRam,          e_addr);
      check("wdata",    oWrDtRam,          e_data);
      check("checksum", oChecksum,         e_sum);
      hs_q = iCoeffValid && oCoeffReady;
      if (rst_n && !oCsnRam && !oWrnRam) begin
        img[oAddrRam] = oWrDtRam;
        nstrobe++;
      end
      if (rst_n && oDone) ndone++;
    end
  end

  // Source driver: advances past each accepted word, valid pattern by mode.
  initial begin : feeder
    forever begin
      @(posedge clk);
      #2;
      if (hs_q) si++;
      cyc3++;
      case (vmode)
        1:       iCoeffValid = (si < nwords);
        2:       iCoeffValid = (si < nwords) && (cyc3 % 3 == 0);
        3:       iCoeffValid = (si < nwords) && ($urandom_range(0, 1) == 1);
        default: iCoeffValid = 1'b0;
      endcase
      iCoeffData = (si < nwords) ? src[si] : 16'h0000;
    end
  end

  task automatic setup_src(input int mode, input int n, input int kind);
    for (int i = 0; i < 64; i++) begin
      case (kind)
        0:       src[i] = 16'(i + 1);
        1:       src[i] = 16'(32'hFFFF - i);
        default: src[i] = 16'($urandom);
      endcase
      img[i] = 16'hxxxx;
    end
    vmode = mode; nwords = n; si = 0; hs_q = 0;
    nstrobe = 0; ndone = 0;
  endtask

  task automatic start_load();
    @(posedge clk); #1 iStart = 1'b1;
    @(posedge clk); #1 iStart = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!oDone && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("done_seen", oDone, 1'b1);
  endtask

  task automatic check_image(input string name);
    int bad = 0;
    for (int i = 0; i < NT; i++) if (img[i] !== src[i]) bad++;
    check({name, "_image_bad"}, bad, 0);
    check({name, "_strobes"}, nstrobe, NT);
  endtask

  task automatic wait_strobe(input int addr, output bit found);
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk); #1;
      if (!oCsnRam && oAddrRam == 6'(addr)) found = 1;
    end
  endtask

  initial begin : main
    int cyc;
    bit found;
    iStart = 0; iAbort = 0; iCoeffValid = 0; iCoeffData = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_csn", oCsnRam, 1'b1);
    check("rst_flag", oCoeffiUpdateFlag, 1'b0);
    check("rst_ready", oCoeffReady, 1'b0);

    // Basic load, valid always high.
    setup_src(1, NT, 0);
    start_load();
    check("setup_flag", oCoeffiUpdateFlag, 1'b1);
    check("setup_busy", oBusy, 1'b1);
    check("setup_ready", oCoeffReady, 1'b1);
    wait_done(cyc);
    check("basic_latency", cyc, NT + 4);
    check("done_flag_low", oCoeffiUpdateFlag, 1'b0);
`ifdef COEFF_CHECKSUM_EN
    check("basic_sum", oChecksum, 16'h0231);
`else
    check("basic_sum", oChecksum, 16'h0000);
`endif
    @(posedge clk); #1;
    check("after_done_busy", oBusy, 1'b0);
    check_image("basic");

    // Sparse input, valid every third cycle.
    setup_src(2, NT, 1);
    start_load();
    wait_done(cyc);
`ifdef COEFF_CHECKSUM_EN
    // Sum of -1 .. -33 modulo 2^16.
    check("sparse_sum", oChecksum, 16'hFDCF);
`endif
    @(posedge clk); #1;
    check("sparse_done_once", ndone, 1);
    check_image("sparse");

    // Abort after the strobe to address 9.
    setup_src(1, NT, 2);
    start_load();
    wait_strobe(9, found);
    check("abort_reach9", found, 1'b1);
    iAbort = 1'b1;
    @(posedge clk); #1 iAbort = 1'b0;
    check("abort_flag", oCoeffiUpdateFlag, 1'b0);
    check("abort_csn", oCsnRam, 1'b1);
    check("abort_busy", oBusy, 1'b0);
    repeat (5) @(posedge clk); #1;
    check("abort_no_done", ndone, 0);
    check("abort_strobes", nstrobe, 10);
    setup_src(3, NT, 2);
    start_load();
    wait_done(cyc);
    check_image("post_abort");

    // Overrun: 40 words offered, only NT taken.
    setup_src(1, 40, 0);
    start_load();
    wait_done(cyc);
    check("overrun_ready", oCoeffReady, 1'b0);
    repeat (3) @(posedge clk); #1;
    check("overrun_taken", si, NT);
    check_image("overrun");

    // Start pulsed mid-load is ignored.
    setup_src(1, NT, 2);
    start_load();
    repeat (10) @(posedge clk);
    #1 iStart = 1'b1;
    @(posedge clk); #1 iStart = 1'b0;
    wait_done(cyc);
    repeat (3) @(posedge clk); #1;
    check("midstart_done_once", ndone, 1);
    check_image("midstart");

    // Start and abort together in IDLE: stay idle.
    iStart = 1'b1; iAbort = 1'b1;
    @(posedge clk); #1 iStart = 1'b0; iAbort = 1'b0;
    check("startabort_busy", oBusy, 1'b0);
    @(posedge clk); #1;
    check("startabort_flag", oCoeffiUpdateFlag, 1'b0);

    // Reset in the middle of a load.
    setup_src(1, NT, 2);
    start_load();
    wait_strobe(15, found);
    check("rst_reach15", found, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mrst_flag", oCoeffiUpdateFlag, 1'b0);
    check("mrst_csn", oCsnRam, 1'b1);
    check("mrst_wrn", oWrnRam, 1'b1);
    check("mrst_addr", oAddrRam, 6'd0);
    check("mrst_data", oWrDtRam, 16'h0000);
    check("mrst_ready", oCoeffReady, 1'b0);
    check("mrst_busy", oBusy, 1'b0);
    check("mrst_done", oDone, 1'b0);
    check("mrst_sum", oChecksum, 16'h0000);
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    setup_src(3, NT, 2);
    start_load();
    wait_done(cyc);
    check_image("post_reset");

    // Randomised loads.
    repeat (3) begin
      setup_src(3, NT + int'($urandom_range(0, 6)), 2);
      start_load();
      wait_done(cyc);
      check_image("random");
    end

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
